// File: rtl/popcount_accum_stage_pkg.sv
// ---------------------------------------------------------------------------
// popcount_accum_stage_pkg
// Shared definitions for the popcount accumulator stage: datapath widths,
// chunking of the iterative popcount, and the FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package popcount_accum_stage_pkg;

    // Word / accumulator width is fixed by the downstream 63+6 adder stage.
    localparam int WORD_W = 63;
    // Popcount of a WORD_W-bit word fits in ceil(log2(WORD_W+1)) bits.
    localparam int CNT_W  = 6;
    // Bits counted per COUNT cycle, and the number of COUNT cycles per word.
    localparam int CHUNK  = 8;
    localparam int NCHUNK = (WORD_W + CHUNK - 1) / CHUNK;
    // Chunk index width; NCHUNK = 8 needs 3 bits.
    localparam int IDX_W  = $clog2(NCHUNK);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_ACC   = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

endpackage : popcount_accum_stage_pkg

// File: rtl/customAdder63_57.sv
// ---------------------------------------------------------------------------
// customAdder63_57
// 63-bit + 6-bit unsigned adder; B is zero-extended by 57 bits.
// Ports:
//   A    in  63  accumulator operand
//   B    in  6   popcount operand
//   Sum  out 64  A + B, Sum[63] is the carry-out
// ---------------------------------------------------------------------------
module customAdder63_57 (
    input  logic [62:0] A,
    input  logic [5:0]  B,
    output logic [63:0] Sum
);

    assign Sum = {1'b0, A} + {58'b0, B};

endmodule : customAdder63_57

// File: rtl/popcount_accum_stage_popcnt_chunk.sv
// ---------------------------------------------------------------------------
// popcnt_chunk
// Combinational population count of one CHUNK-bit slice of the input word.
// Ports:
//   bits_i   in  CHUNK  slice to count
//   count_o  out CNT_W  number of set bits in bits_i (zero-extended)
// ---------------------------------------------------------------------------
module popcnt_chunk
    import popcount_accum_stage_pkg::*;
(
    input  logic [CHUNK-1:0] bits_i,
    output logic [CNT_W-1:0] count_o
);

    // NOTE: count_o is assigned before the loop so every path drives it and
    // no latch is inferred.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count_o = count_o + CNT_W'(bits_i[i]);
        end
    end

endmodule : popcnt_chunk

// File: rtl/popcount_accum_stage.sv
// ---------------------------------------------------------------------------
// popcount_accum_stage
// Accepts 63-bit words over valid/ready, counts their set bits CHUNK bits per
// cycle, adds the count to a running 63-bit accumulator and presents the new
// total downstream. Adder carry-out sets a sticky overflow flag.
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   in_word valid
//   in_ready   out  1   stage can accept a word (IDLE only)
//   in_word    in   63  word to count
//   clear      in   1   load accumulator with init_val, clear overflow (IDLE only)
//   init_val   in   63  accumulator value loaded on clear
//   out_valid  out  1   result valid; held until out_ready
//   out_ready  in   1   downstream accepts result
//   out_acc    out  63  accumulator after this word (modulo 2^63)
//   out_count  out  6   popcount of the last accepted word
//   out_ovf    out  1   sticky carry-out of any accumulate
// ---------------------------------------------------------------------------
module popcount_accum_stage
    import popcount_accum_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic              clear,
    input  logic [WORD_W-1:0] init_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_e              state_q,     state_d;
    logic [WORD_W-1:0]   shreg_q,     shreg_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [WORD_W-1:0]   acc_q,       acc_d;
    logic                ovf_q,       ovf_d;
    logic [CNT_W-1:0]    out_count_q, out_count_d;
    logic                out_valid_q, out_valid_d;

    logic [CNT_W-1:0]    chunk_cnt;
    logic [WORD_W:0]     sum;

    // Low chunk of the shift register; the register shifts right each COUNT
    // cycle, so the final chunk picks up a zero in its top bit.
    popcnt_chunk u_popcnt_chunk (
        .bits_i  (shreg_q[CHUNK-1:0]),
        .count_o (chunk_cnt)
    );

    customAdder63_57 u_adder (
        .A   (acc_q),
        .B   (cnt_q),
        .Sum (sum)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                // clear takes effect on the same edge that accepts a word;
                // the accumulate happens later in ACC, so the word lands on
                // init_val.
                if (clear) begin
                    acc_d = init_val;
                    ovf_d = 1'b0;
                end
                if (in_valid) begin
                    shreg_d = in_word;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                cnt_d   = cnt_q + chunk_cnt;
                shreg_d = shreg_q >> CHUNK;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(NCHUNK - 1)) begin
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                acc_d       = sum[WORD_W-1:0];
                ovf_d       = ovf_q | sum[WORD_W];
                out_count_d = cnt_q;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_count = out_count_q;
    assign out_ovf   = ovf_q;

endmodule : popcount_accum_stage

// File: tb/tb_popcount_accum_stage.sv
// ---------------------------------------------------------------------------
// tb_popcount_accum_stage
// Scoreboard bench: each accepted word pushes its expected result (from an
// independent accumulator model); each output handshake pops and compares.
// ---------------------------------------------------------------------------
module tb_popcount_accum_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [62:0] in_word;
    logic        clear;
    logic [62:0] init_val;
    logic        out_valid;
    logic        out_ready;
    logic [62:0] out_acc;
    logic [5:0]  out_count;
    logic        out_ovf;

    typedef struct packed {
        logic [62:0] acc;
        logic [5:0]  count;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    logic [62:0] m_acc;
    logic        m_ovf;
    int          n_checks = 0;
    int          n_fail   = 0;

    popcount_accum_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .clear     (clear),
        .init_val  (init_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: a handshake is sampled on the falling edge before the
    // rising edge that completes it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_acc",   64'(out_acc),   64'(e.acc));
                check("out_count", 64'(out_count), 64'(e.count));
                check("out_ovf",   64'(out_ovf),   64'(e.ovf));
            end
        end
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        sb.delete();
        m_acc    = '0;
        m_ovf    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
    endtask

    // Drive one word; returns 1 ns after the accepting rising edge.
    task automatic send(input logic [62:0] word, input logic clr, input logic [62:0] init);
        int   w;
        exp_t e;
        logic [63:0] s;
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = word;
        clear    = clr;
        init_val = init;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            if (clr) begin
                m_acc = init;
                m_ovf = 1'b0;
            end
            s       = {1'b0, m_acc} + 64'($countones(word));
            m_ovf   = m_ovf | s[63];
            m_acc   = s[62:0];
            e.acc   = m_acc;
            e.count = 6'($countones(word));
            e.ovf   = m_ovf;
            sb.push_back(e);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic do_clear(input logic [62:0] init);
        @(negedge clk);
        clear    = 1'b1;
        init_val = init;
        @(negedge clk);
        clear    = 1'b0;
        m_acc    = init;
        m_ovf    = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || out_valid) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_timeout", 64'(w >= 200), 64'd0);
    endtask

    initial begin
        int   n;
        logic seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        clear     = 1'b0;
        init_val  = '0;
        out_ready = 1'b1;

        // T1: reset state, then all-ones word and its latency.
        do_reset();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_acc",   64'(out_acc),   64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        send(63'h7FFF_FFFF_FFFF_FFFF, 1'b0, '0);
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'd9);
        check("t1_acc_const", 64'(out_acc), 64'd63);
        wait_drain();

        // T2: back-to-back small words from a zero accumulator.
        do_reset();
        send(63'd1, 1'b0, '0);
        send(63'd3, 1'b0, '0);
        send(63'd7, 1'b0, '0);
        wait_drain();
        check("t2_acc_const", 64'(out_acc), 64'd6);

        // T3: downstream stall; outputs hold, input side is blocked.
        out_ready = 1'b0;
        send(63'h5555, 1'b0, '0);
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            @(negedge clk);
            check("stall_valid",    64'(out_valid), 64'd1);
            check("stall_acc",      64'(out_acc),   64'(sb[0].acc));
            check("stall_in_ready", 64'(in_ready),  64'd0);
            in_valid = 1'b1;
            in_word  = 63'h7FFF;
            clear    = 1'b1;
            init_val = 63'd999;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("t3_acc_after", 64'(out_acc), 64'd14);

        // T4: wrap-around sets the sticky overflow.
        do_reset();
        do_clear(63'h7FFF_FFFF_FFFF_FFF6);
        send(63'h7FFF_FFFF_FFFF_FFFF, 1'b0, '0);
        wait_drain();
        check("t4_acc",  64'(out_acc), 64'd53);
        check("t4_ovf",  64'(out_ovf), 64'd1);
        send(63'd0, 1'b0, '0);
        wait_drain();
        check("t4_acc_zero", 64'(out_acc), 64'd53);
        check("t4_ovf_held", 64'(out_ovf), 64'd1);

        // T5: reset in the middle of COUNT discards the word.
        send(63'h1234_5678, 1'b0, '0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_acc = '0;
        m_ovf = 1'b0;
        #1;
        check("midrst_valid",    64'(out_valid), 64'd0);
        check("midrst_acc",      64'(out_acc),   64'd0);
        check("midrst_ovf",      64'(out_ovf),   64'd0);
        check("midrst_in_ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("midrst_no_out", 64'(seen), 64'd0);
        send(63'hF, 1'b0, '0);
        wait_drain();
        check("t5_acc", 64'(out_acc), 64'd4);

        // T6: clear and word accepted in the same IDLE cycle.
        do_reset();
        send(63'hFF, 1'b1, 63'd100);
        wait_drain();
        check("t6_acc", 64'(out_acc), 64'd108);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_popcount_accum_stage
